sha3_block_padder: RTL and testbench
====================================

# sha3_block_padder

Upstream feeder for the SHA3-256 absorb/round datapath. It accepts the message as a stream of 64-bit little-endian words with a valid/ready handshake. It applies SHA3 pad10*1 padding and assembles 1088-bit rate blocks. Each block is presented to the absorb stage with a valid/ready handshake and a last-block flag, replacing the free-running scan-chain loader with a flow-controlled, single-clock source.

## Interface
- RATE_WORDS, 17, number of 64-bit words per rate block (17 × 64 = 1088 bits)
- clk  input  1  system clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-high reset
- in_data  input  64  message word; byte i occupies bits [8i+7:8i]
- in_valid  input  1  in_data/in_last/in_bytes are valid
- in_last  input  1  this word is the final message word
- in_bytes  input  4  valid bytes in the final word, 0..8; ignored when in_last=0; values >8 are treated as 8
- in_ready  output  1  padder accepts a word this cycle
- block  output  1088  assembled rate block; word k at bits [64k+63:64k]
- block_valid  output  1  block is complete and stable
- block_last  output  1  block is the final (padded) block of the message
- block_ready  input  1  absorb stage accepts the block this cycle

## Operation
- States:
  - FILL: collecting words.
  - HOLD: block presented.
  - PAD_ONLY: padding-only block pending.
- Word transfer: occurs when in_valid && in_ready. in_ready = (state == FILL).
- Word placement: an accepted word is written to block word word_cnt (range 0..RATE_WORDS-1), and word_cnt increments.
- Non-last word: if word_cnt reaches RATE_WORDS, go to HOLD with block_last=0 and word_cnt=0.
- Last word: let p = 8·word_cnt + min(in_bytes,8), the byte index of the first pad byte within the block.
  - Bytes ≥ in_bytes of that word are zeroed.
  - If p < 8·RATE_WORDS: byte p ^= 0x06 and byte 8·RATE_WORDS−1 ^= 0x80. All words after word_cnt are zero. Go to HOLD with block_last=1. When p = 8·RATE_WORDS−1, the result is the single byte 0x86.
  - If p == 8·RATE_WORDS (message ends exactly on a block boundary): go to HOLD with block_last=0 and record pad_pending=1.
- HOLD: block_valid=1 and block stays stable. On block_ready:
  - If pad_pending: go to PAD_ONLY. The block is reloaded as all-zero with byte 0=0x06 and byte 135=0x80, and block_last is set.
  - Otherwise: clear the block to zero and return to FILL.
- PAD_ONLY: behaves like HOLD with block_valid=1 and block_last=1. On block_ready, clear pad_pending and return to FILL.
- Block buffer: unfilled words are always zero, because the buffer is cleared on every block handoff.
- Messages: back-to-back messages need no idle cycle.

## Timing
- Reset values:
  - state=FILL, word_cnt=0, pad_pending=0
  - block=0, block_valid=0, block_last=0
  - in_ready=1 (combinational from state)
- Reset mid-operation: the partial block and any pending pad are discarded.
- Latency: block_valid rises on the cycle after the transfer of the completing word.
- Handoff: block_valid falls on the cycle after block_ready is sampled high. in_ready rises in the same cycle (or PAD_ONLY is entered instead).
- Backpressure: while block_valid=1 and block_ready=0, in_ready=0 and block/block_last are held.
- block_ready while block_valid=0: ignored.
- No combinational path exists from block_ready to in_ready or from in_valid to block_valid.

## Configuration
- KECCAK_LEGACY_PAD_EN
  - Defined: the domain byte is 0x01 instead of 0x06 (original Keccak padding). A one-byte pad at the last position becomes 0x81.
  - Undefined: FIPS 202 SHA3 domain byte 0x06.
- Nothing else changes.

## Test plan
- Empty message: one word with in_last=1, in_bytes=0 → one block with byte0=0x06, byte135=0x80, all else 0, block_last=1.
- "abc": word 0x0000000000636261, in_last=1, in_bytes=3 → block word0=0x0000000006636261, byte135=0x80, block_last=1.
- 135-byte message: 16 full words, then word 16 with in_bytes=7 → byte135=0x86, one block, block_last=1.
- 136-byte message: 17 full words with in_last on the 17th →
  - first block: data, block_last=0;
  - after handoff: pad-only block with 0x06…0x80, block_last=1.
- Backpressure: hold block_ready=0 for 5 cycles after block_valid → in_ready=0 and block unchanged throughout; handoff on the 6th cycle; in_ready=1 on the next cycle.
- Reset asserted after 5 words of a message → block=0, block_valid=0, word_cnt restarts at 0. A following "abc" message produces the same block as the directed "abc" case.
- With KECCAK_LEGACY_PAD_EN defined: rerun the empty-message case → byte0=0x01, byte135=0x80.

Source files
------------

// File: rtl/sha3_block_padder.sv
// -----------------------------------------------------------------------------
// sha3_block_padder
//
// Purpose:
//   Collects a message delivered as 64-bit little-endian words and applies
//   pad10*1 padding with the SHA3 domain byte. It assembles 1088-bit rate
//   blocks and hands each one to the absorb stage over a valid/ready
//   handshake. The final block of a message is flagged with block_last.
//   A message that ends exactly on a block boundary produces one extra
//   padding-only block.
//
// Configuration macro:
//   KECCAK_LEGACY_PAD_EN - when defined, the domain byte is 0x01 (original
//                          Keccak padding). Otherwise it is 0x06 (FIPS 202).
//
// Ports:
//   clk          in   1     system clock, rising edge
//   reset        in   1     asynchronous active-high reset
//   in_data      in   64    message word, byte i at bits [8i+7:8i]
//   in_valid     in   1     in_data/in_last/in_bytes valid
//   in_last      in   1     final word of the message
//   in_bytes     in   4     valid bytes in final word (0..8, >8 means 8)
//   in_ready     out  1     word accepted this cycle when in_valid
//   block        out  1088  rate block, word k at bits [64k+63:64k]
//   block_valid  out  1     block complete and stable
//   block_last   out  1     block is the final padded block
//   block_ready  in   1     absorb stage takes the block this cycle
// -----------------------------------------------------------------------------
module sha3_block_padder #(
    parameter int RATE_WORDS = 17
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [63:0]               in_data,
    input  logic                      in_valid,
    input  logic                      in_last,
    input  logic [3:0]                in_bytes,
    output logic                      in_ready,
    output logic [64*RATE_WORDS-1:0]  block,
    output logic                      block_valid,
    output logic                      block_last,
    input  logic                      block_ready
);

    localparam int CNT_W = $clog2(RATE_WORDS);
    // Byte-position width: word index plus 3 bits for the byte, plus one
    // bit of headroom so that "one past the end of the block" is representable.
    localparam int P_W   = CNT_W + 4;

    localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(RATE_WORDS - 1);
    localparam logic [P_W-1:0]   RATE_BYTES = P_W'(8 * RATE_WORDS);

`ifdef KECCAK_LEGACY_PAD_EN
    localparam logic [7:0] DOM_BYTE = 8'h01;
`else
    localparam logic [7:0] DOM_BYTE = 8'h06;
`endif

    // The closing pad bit always lands in the top byte of the last word.
    localparam logic [63:0] END_WORD = 64'h8000_0000_0000_0000;

    typedef enum logic [1:0] {
        ST_FILL     = 2'd0,
        ST_HOLD     = 2'd1,
        ST_PAD_ONLY = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_word_cnt;
    logic               r_pad_pending;
    logic               r_block_last;

    logic               w_accept;
    logic               w_handoff;
    logic               w_load_pad;
    logic               w_clear;

    logic [3:0]         w_nbytes;
    logic [63:0]        w_masked;
    logic [P_W-1:0]     w_p;
    logic [CNT_W:0]     w_p_word;
    logic [2:0]         w_p_byte;
    logic               w_pad_now;
    logic               w_pad_defer;
    logic [63:0]        w_dom_word;
    logic               w_block_done;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_FILL;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and control strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_handoff    = 1'b0;
        w_load_pad   = 1'b0;
        case (r_state)
            ST_FILL: begin
                w_accept = in_valid;
                if (in_valid && w_block_done) begin
                    w_state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (block_ready) begin
                    w_handoff = 1'b1;
                    if (r_pad_pending) begin
                        w_load_pad   = 1'b1;
                        w_state_next = ST_PAD_ONLY;
                    end else begin
                        w_state_next = ST_FILL;
                    end
                end
            end
            ST_PAD_ONLY: begin
                if (block_ready) begin
                    w_handoff    = 1'b1;
                    w_state_next = ST_FILL;
                end
            end
            default: begin
                w_state_next = ST_FILL;
            end
        endcase
    end

    // Every handoff clears the buffer, except the one that reloads it with
    // the padding-only block.
    assign w_clear = w_handoff && !w_load_pad;

    assign in_ready    = (r_state == ST_FILL);
    assign block_valid = (r_state != ST_FILL);
    assign block_last  = r_block_last;

    // ------------------------------------------------------------------
    // Incoming word: byte masking and pad position
    // ------------------------------------------------------------------
    assign w_nbytes     = (in_bytes > 4'd8) ? 4'd8 : in_bytes;
    assign w_block_done = in_last || (r_word_cnt == LAST_CNT);

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_mask
            // Non-final words pass through untouched; the final word keeps
            // only its first w_nbytes bytes.
            assign w_masked[8*gi +: 8] = (!in_last || (4'(gi) < w_nbytes)) ?
                                         in_data[8*gi +: 8] : 8'h00;
        end
    endgenerate

    // p = byte index of the first pad byte within the block
    assign w_p         = {1'b0, r_word_cnt, 3'b000} + {{(P_W-4){1'b0}}, w_nbytes};
    assign w_p_word    = w_p[P_W-1:3];
    assign w_p_byte    = w_p[2:0];
    assign w_pad_now   = in_last && (w_p <  RATE_BYTES);
    assign w_pad_defer = in_last && (w_p == RATE_BYTES);
    assign w_dom_word  = {56'd0, DOM_BYTE} << {w_p_byte, 3'b000};

    // ------------------------------------------------------------------
    // Block buffer, one register per rate word
    // ------------------------------------------------------------------
    generate
        for (gi = 0; gi < RATE_WORDS; gi++) begin : g_word
            localparam logic [63:0] PAD_ONLY_WORD =
                ((gi == 0) ? {56'd0, DOM_BYTE} : 64'd0) ^
                ((gi == RATE_WORDS - 1) ? END_WORD : 64'd0);

            logic [63:0] r_word;
            logic [63:0] w_word_next;

            // The domain byte may fall in the word being written or, when the
            // final word is full, in the following (still zero) word. The
            // closing 0x80 XORs into the top word so that both pad bits
            // merge into 0x86 when they share a byte.
            always_comb begin
                w_word_next = r_word;
                if (r_word_cnt == CNT_W'(gi)) begin
                    w_word_next = w_masked;
                end
                if (w_pad_now) begin
                    if (w_p_word == (CNT_W+1)'(gi)) begin
                        w_word_next = w_word_next ^ w_dom_word;
                    end
                    if (gi == RATE_WORDS - 1) begin
                        w_word_next = w_word_next ^ END_WORD;
                    end
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_word <= 64'd0;
                end else if (w_clear) begin
                    r_word <= 64'd0;
                end else if (w_load_pad) begin
                    r_word <= PAD_ONLY_WORD;
                end else if (w_accept) begin
                    r_word <= w_word_next;
                end
            end

            assign block[64*gi +: 64] = r_word;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Word counter, pending pad and last-block flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_word_cnt    <= '0;
            r_pad_pending <= 1'b0;
            r_block_last  <= 1'b0;
        end else begin
            if (w_accept) begin
                if (w_block_done) begin
                    r_word_cnt <= '0;
                end else begin
                    r_word_cnt <= r_word_cnt + 1'b1;
                end
                if (in_last) begin
                    r_block_last  <= w_pad_now;
                    r_pad_pending <= w_pad_defer;
                end else if (r_word_cnt == LAST_CNT) begin
                    r_block_last  <= 1'b0;
                end
            end
            if (w_load_pad) begin
                r_block_last <= 1'b1;
            end else if (w_handoff) begin
                r_block_last  <= 1'b0;
                r_pad_pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sha3_block_padder.sv
module tb_sha3_block_padder;

    localparam int RW = 17;

`ifdef KECCAK_LEGACY_PAD_EN
    localparam logic [7:0] DOM = 8'h01;
`else
    localparam logic [7:0] DOM = 8'h06;
`endif

    logic              clk;
    logic              reset;
    logic [63:0]       in_data;
    logic              in_valid;
    logic              in_last;
    logic [3:0]        in_bytes;
    logic              in_ready;
    logic [64*RW-1:0]  block;
    logic              block_valid;
    logic              block_last;
    logic              block_ready;

    int tests;
    int fails;

    sha3_block_padder #(.RATE_WORDS(RW)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_last     (in_last),
        .in_bytes    (in_bytes),
        .in_ready    (in_ready),
        .block       (block),
        .block_valid (block_valid),
        .block_last  (block_last),
        .block_ready (block_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (observed timeout, required $finish)");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_blk(input string tag, input logic [64*RW-1:0] exp);
        for (int k = 0; k < RW; k++) begin
            chk($sformatf("%s.w%0d", tag, k), block[64*k +: 64], exp[64*k +: 64]);
        end
    endtask

    // Called at a falling edge; the word transfers on the next rising edge.
    task automatic send_word(input logic [63:0] d, input logic last, input logic [3:0] nb);
        in_data  = d;
        in_last  = last;
        in_bytes = nb;
        in_valid = 1'b1;
        chk("in_ready_before_word", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
    endtask

    task automatic end_msg();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 64'd0;
        in_bytes = 4'd0;
    endtask

    task automatic handoff();
        block_ready = 1'b1;
        @(negedge clk);
        block_ready = 1'b0;
    endtask

    task automatic chk_hold(input string tag, input logic last, input logic [64*RW-1:0] exp);
        chk({tag, ".valid"},    {63'd0, block_valid}, 64'd1);
        chk({tag, ".last"},     {63'd0, block_last},  {63'd0, last});
        chk({tag, ".in_ready"}, {63'd0, in_ready},    64'd0);
        chk_blk(tag, exp);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".valid"},    {63'd0, block_valid}, 64'd0);
        chk({tag, ".in_ready"}, {63'd0, in_ready},    64'd1);
        chk({tag, ".last"},     {63'd0, block_last},  64'd0);
    endtask

    function automatic logic [63:0] pat(input int k);
        logic [7:0] kb;
        kb = 8'(k);
        return {kb, 8'hA1, kb, 8'hB2, kb, 8'hC3, kb, 8'hD4};
    endfunction

    logic [64*RW-1:0] exp_empty;
    logic [64*RW-1:0] exp_abc;
    logic [64*RW-1:0] exp_8b;
    logic [64*RW-1:0] exp_135;
    logic [64*RW-1:0] exp_136;
    logic [63:0]      w16;

    initial begin
        tests       = 0;
        fails       = 0;
        reset       = 1'b1;
        in_data     = 64'd0;
        in_valid    = 1'b0;
        in_last     = 1'b0;
        in_bytes    = 4'd0;
        block_ready = 1'b0;

        // Hand-computed expected blocks
        exp_empty = '0;
        exp_empty[7:0]         = DOM;
        exp_empty[1087:1080]   = 8'h80;

        exp_abc = '0;
        exp_abc[63:0]          = {32'd0, DOM, 24'h636261};
        exp_abc[1087:1080]     = 8'h80;

        exp_8b = '0;
        exp_8b[63:0]           = 64'h0807_0605_0403_0201;
        exp_8b[71:64]          = DOM;
        exp_8b[1087:1080]      = 8'h80;

        exp_135 = '0;
        for (int k = 0; k < RW - 1; k++) exp_135[64*k +: 64] = pat(k);
        w16 = pat(16);
        exp_135[64*16 +: 64]   = {DOM | 8'h80, w16[55:0]};

        exp_136 = '0;
        for (int k = 0; k < RW; k++) exp_136[64*k +: 64] = pat(k);

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("reset.valid",    {63'd0, block_valid}, 64'd0);
        chk("reset.last",     {63'd0, block_last},  64'd0);
        chk("reset.in_ready", {63'd0, in_ready},    64'd1);
        chk_blk("reset.block", '0);
        reset = 1'b0;
        @(negedge clk);

        // block_ready while no block is presented is ignored
        handoff();
        chk_idle("ready_idle");
        chk_blk("ready_idle.block", '0);

        // Empty message; junk data must be masked away
        send_word(64'hDEAD_BEEF_0000_1111, 1'b1, 4'd0);
        end_msg();
        chk_hold("empty", 1'b1, exp_empty);
        handoff();
        chk_idle("empty.after");
        chk_blk("empty.cleared", '0);

        // "abc" with five cycles of backpressure; a word offered meanwhile is refused
        send_word(64'h0000_0000_0063_6261, 1'b1, 4'd3);
        end_msg();
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            in_last  = 1'b1;
            in_data  = 64'hFFFF_FFFF_FFFF_FFFF;
            in_bytes = 4'd8;
            chk_hold($sformatf("abc_bp%0d", c), 1'b1, exp_abc);
            @(negedge clk);
        end
        end_msg();
        chk_hold("abc_bp5", 1'b1, exp_abc);
        handoff();
        chk_idle("abc.after");

        // "abc" with garbage above the valid bytes
        send_word(64'hFFFF_FFFF_FF63_6261, 1'b1, 4'd3);
        end_msg();
        chk_hold("abc_garbage", 1'b1, exp_abc);
        handoff();
        chk_idle("abc_garbage.after");

        // 8-byte message with in_bytes=15 (treated as 8): pad opens word 1
        send_word(64'h0807_0605_0403_0201, 1'b1, 4'd15);
        end_msg();
        chk_hold("msg8_b15", 1'b1, exp_8b);
        handoff();
        chk_idle("msg8_b15.after");

        // 135-byte message: both pad bits share byte 135
        for (int k = 0; k < RW - 1; k++) send_word(pat(k), 1'b0, 4'd0);
        send_word(pat(16), 1'b1, 4'd7);
        end_msg();
        chk_hold("msg135", 1'b1, exp_135);
        handoff();
        chk_idle("msg135.after");

        // 136-byte message: data block, then a padding-only block
        for (int k = 0; k < RW - 1; k++) send_word(pat(k), 1'b0, 4'd5);
        send_word(pat(16), 1'b1, 4'd8);
        end_msg();
        chk_hold("msg136.data", 1'b0, exp_136);
        handoff();
        chk_hold("msg136.pad", 1'b1, exp_empty);
        handoff();
        chk_idle("msg136.after");

        // Reset after five words discards the partial block
        for (int k = 0; k < 5; k++) send_word(pat(k + 40), 1'b0, 4'd0);
        end_msg();
        reset = 1'b1;
        #1;
        chk_idle("midreset");
        chk_blk("midreset.block", '0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        send_word(64'h0000_0000_0063_6261, 1'b1, 4'd3);
        end_msg();
        chk_hold("abc_after_reset", 1'b1, exp_abc);
        handoff();
        chk_idle("abc_after_reset.after");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
